// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table + target buffer: combinational lookup, updates visible 1 cycle after the edge.
// No backpressure: one EX update is accepted on every cycle.
module branch_predictor_bht #(
   parameter int IDX_W = 4,
   parameter int PC_W  = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [PC_W-1:0] pc_fetch_bp_i,
   output logic            brn_pred_fetch_bp_o,
   output logic [PC_W-1:0] brn_target_fetch_bp_o,
   input  logic            upd_valid_ex_bp_i,
   input  logic [PC_W-1:0] upd_pc_ex_bp_i,
   input  logic            upd_taken_ex_bp_i,
   input  logic [PC_W-1:0] upd_target_ex_bp_i,
   input  logic            mispred_ex_bp_i,
   output logic [15:0]     mispred_cnt_bp_o
);

   localparam int DEPTH = 1 << IDX_W;
   localparam int TAG_W = PC_W - IDX_W - 2;

   typedef struct packed {
      logic             vld;
      logic [TAG_W-1:0] tag;
      logic [1:0]       ctr;
      logic [PC_W-1:0]  target;
   } entry_t;

   localparam entry_t RST_ENT = '{vld: 1'b0, tag: '0, ctr: 2'b01, target: '0};

   entry_t           tbl_q [DEPTH];
   entry_t           lk_ent;
   entry_t           upd_cur;
   entry_t           upd_ent_d;
   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   logic             lk_pred;
   logic [15:0]      cnt_q;
   logic [15:0]      cnt_d;

   // Word alignment means the low PC bits carry no information.
   logic unused_pc_lsb;
   assign unused_pc_lsb = ^{pc_fetch_bp_i[1:0], upd_pc_ex_bp_i[1:0]};

   always_comb begin
      lk_idx  = pc_fetch_bp_i[IDX_W+1:2];
      lk_ent  = tbl_q[lk_idx];
      lk_pred = lk_ent.vld && (lk_ent.tag == pc_fetch_bp_i[PC_W-1:IDX_W+2]) && lk_ent.ctr[1];
   end

   assign brn_pred_fetch_bp_o   = lk_pred;
   assign brn_target_fetch_bp_o = lk_pred ? lk_ent.target : '0;
   assign mispred_cnt_bp_o      = cnt_q;

   always_comb begin
      upd_idx   = upd_pc_ex_bp_i[IDX_W+1:2];
      upd_tag   = upd_pc_ex_bp_i[PC_W-1:IDX_W+2];
      upd_cur   = tbl_q[upd_idx];
      upd_hit   = upd_cur.vld && (upd_cur.tag == upd_tag);
      upd_ent_d = upd_cur;
      if (upd_hit) begin
         if (upd_taken_ex_bp_i) begin
            upd_ent_d.ctr    = (upd_cur.ctr == 2'b11) ? 2'b11 : 2'(upd_cur.ctr + 2'd1);
            upd_ent_d.target = upd_target_ex_bp_i;
         end else begin
            upd_ent_d.ctr    = (upd_cur.ctr == 2'b00) ? 2'b00 : 2'(upd_cur.ctr - 2'd1);
         end
      end else begin
         // Direct mapped: a miss always takes over the slot.
         upd_ent_d.vld    = 1'b1;
         upd_ent_d.tag    = upd_tag;
         upd_ent_d.ctr    = upd_taken_ex_bp_i ? 2'b10 : 2'b01;
         upd_ent_d.target = upd_taken_ex_bp_i ? upd_target_ex_bp_i : '0;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (upd_valid_ex_bp_i && mispred_ex_bp_i && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_q[i] <= RST_ENT;
         end
         cnt_q <= '0;
      end else begin
         if (upd_valid_ex_bp_i) begin
            tbl_q[upd_idx] <= upd_ent_d;
         end
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Randomized bench for branch_predictor_bht against a table-level reference model.
module tb_branch_predictor_bht;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic        pred;
   logic [31:0] tgt;
   logic        uv;
   logic [31:0] upc;
   logic        tk;
   logic [31:0] utg;
   logic        mp;
   logic [15:0] cnt;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   bit          m_vld [16];
   int unsigned m_tag [16];
   int          m_ctr [16];
   logic [31:0] m_tgt [16];
   int          m_cnt;

   always #5 clk = ~clk;

   branch_predictor_bht #(.IDX_W(4), .PC_W(32)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .pc_fetch_bp_i         (pc),
      .brn_pred_fetch_bp_o   (pred),
      .brn_target_fetch_bp_o (tgt),
      .upd_valid_ex_bp_i     (uv),
      .upd_pc_ex_bp_i        (upc),
      .upd_taken_ex_bp_i     (tk),
      .upd_target_ex_bp_i    (utg),
      .mispred_ex_bp_i       (mp),
      .mispred_cnt_bp_o      (cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void exp_lookup(input logic [31:0] a, output logic p, output logic [31:0] t);
      int i;
      i = int'(a[5:2]);
      p = m_vld[i] && (m_tag[i] == (a >> 6)) && (m_ctr[i] >= 2);
      t = p ? m_tgt[i] : 32'h0;
   endfunction

   // Reference model: history as integer counters, applied at each rising edge.
   always @(posedge clk) begin
      int i;
      if (!rst_n) begin
         for (int k = 0; k < 16; k++) begin
            m_vld[k] = 1'b0; m_tag[k] = 0; m_ctr[k] = 1; m_tgt[k] = 32'h0;
         end
         m_cnt = 0;
      end else begin
         if (uv) begin
            i = int'(upc[5:2]);
            if (m_vld[i] && m_tag[i] == (upc >> 6)) begin
               if (tk) begin
                  m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                  m_tgt[i] = utg;
               end else begin
                  m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
               end
            end else begin
               m_vld[i] = 1'b1;
               m_tag[i] = upc >> 6;
               m_ctr[i] = tk ? 2 : 1;
               m_tgt[i] = tk ? utg : 32'h0;
            end
            if (mp && m_cnt < 65535) m_cnt = m_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      logic        ep;
      logic [31:0] et;
      if (chk_en) begin
         exp_lookup(pc, ep, et);
         check("model_pred", {31'b0, pred}, {31'b0, ep});
         check("model_target", tgt, et);
         check("model_cnt", {16'b0, cnt}, m_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ep [6];
      ep = '{1, 1, 1, 1, 0, 0};
      rst_n = 1'b0; pc = 32'h0040_0010; uv = 1'b0; upc = '0; tk = 1'b0; utg = '0; mp = 1'b0;
      tick(); tick();
      rst_n = 1'b1; chk_en = 1'b1;
      #2;
      check("rst_pred", {31'b0, pred}, 32'd0);
      check("rst_target", tgt, 32'h0);
      check("rst_cnt", {16'b0, cnt}, 32'd0);

      uv = 1'b1; upc = 32'h0040_0010; tk = 1'b1; utg = 32'h0040_0100;
      #2 check("first_same_cycle", {31'b0, pred}, 32'd0);
      tick(); uv = 1'b0;
      #2 check("first_pred", {31'b0, pred}, 32'd1);
      check("first_target", tgt, 32'h0040_0100);
      pc = 32'h0040_0014;
      #2 check("neighbour_pred", {31'b0, pred}, 32'd0);
      tick();

      rst_n = 1'b0; tick(); rst_n = 1'b1;
      pc = 32'h0040_0010;
      #2 check("reset_erase", {31'b0, pred}, 32'd0);
      for (int k = 0; k < 6; k++) begin
         uv = 1'b1; upc = 32'h0040_0010; tk = (k < 3); utg = 32'h0040_0100;
         tick(); uv = 1'b0;
         #2 check($sformatf("ctr_path%0d", k), {31'b0, pred}, ep[k]);
      end

      rst_n = 1'b0; tick(); rst_n = 1'b1;
      uv = 1'b1; upc = 32'h0040_0010; tk = 1'b1; utg = 32'h0040_0200;
      tick();
      upc = 32'h0040_0050; tk = 1'b0;
      tick(); uv = 1'b0;
      pc = 32'h0040_0010;
      #2 check("alias_old", {31'b0, pred}, 32'd0);
      pc = 32'h0040_0050;
      #2 check("alias_new", {31'b0, pred}, 32'd0);
      check("alias_new_tgt", tgt, 32'h0);

      pc = 32'h0040_0020; uv = 1'b1; upc = 32'h0040_0020; tk = 1'b1; utg = 32'h0040_1234;
      #2 check("bypass_none", {31'b0, pred}, 32'd0);
      tick(); uv = 1'b0;
      #2 check("bypass_next", {31'b0, pred}, 32'd1);
      check("bypass_tgt", tgt, 32'h0040_1234);

      for (int n = 0; n < 3000; n++) begin
         pc    = 32'h0040_0000 | ($urandom_range(0, 63) << 2);
         upc   = 32'h0040_0000 | ($urandom_range(0, 63) << 2);
         utg   = $urandom & 32'hFFFF_FFFC;
         uv    = 1'($urandom_range(0, 1));
         tk    = 1'($urandom_range(0, 1));
         mp    = 1'($urandom_range(0, 1));
         rst_n = ($urandom_range(0, 199) != 0);
         tick();
      end

      rst_n = 1'b1; uv = 1'b1; mp = 1'b1; upc = 32'h0040_0010; tk = 1'b1;
      repeat (70000) tick();
      check("cnt_saturated", {16'b0, cnt}, 32'h0000_FFFF);

      rst_n = 1'b0; upc = 32'h0040_0030; tk = 1'b1; utg = 32'h0040_0300;
      tick();
      rst_n = 1'b1; uv = 1'b0; mp = 1'b0;
      #2 check("cnt_after_rst", {16'b0, cnt}, 32'd0);
      pc = 32'h0040_0030;
      #2 check("rst_drops_update", {31'b0, pred}, 32'd0);
      pc = 32'h0040_0010;
      #2 check("rst_drops_history", {31'b0, pred}, 32'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Direct-mapped branch history table plus target buffer in the fetch stage.
- Predicts taken/not-taken and the target for each fetch PC.
- Produces the prediction bit carried down the pipe. The hazard unit compares it against the EX branch outcome to decide flushes.
- Trained from the EX stage with resolved branch outcomes.

Parameters:
- IDX_W, 4, index bits; table depth = 2^IDX_W entries.
- PC_W, 32, program counter width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- pc_fetch_bp_i  input  PC_W  current fetch PC, word aligned.
- brn_pred_fetch_bp_o  output  1  predicted taken for pc_fetch_bp_i.
- brn_target_fetch_bp_o  output  PC_W  predicted target; 0 when not predicted taken.
- upd_valid_ex_bp_i  input  1  a conditional branch resolved in EX this cycle.
- upd_pc_ex_bp_i  input  PC_W  PC of the resolved branch.
- upd_taken_ex_bp_i  input  1  actual outcome of the resolved branch.
- upd_target_ex_bp_i  input  PC_W  actual target of the resolved branch.
- mispred_ex_bp_i  input  1  EX prediction disagreed with the outcome; qualified by upd_valid_ex_bp_i.
- mispred_cnt_bp_o  output  16  saturating mispredict count.

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[PC_W-1:IDX_W+2], width PC_W-IDX_W-2.
- Each entry holds: valid bit, tag, 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST), target.
- Lookup is combinational from the fetch PC.
  - Prediction taken = valid & tag match & ctr[1].
  - brn_target_fetch_bp_o = stored target if predicted taken, else 0.
- On update (upd_valid_ex_bp_i=1, rising edge), for the indexed entry:
  - Hit (valid & tag match), taken: ctr increments, saturating at 11; target overwritten with upd_target.
  - Hit, not taken: ctr decrements, saturating at 00; target unchanged.
  - Miss or invalid, taken: allocate. valid=1, tag written, target=upd_target, ctr=10.
  - Miss or invalid, not taken: allocate. valid=1, tag written, target=0, ctr=01.
- Misses always replace (direct mapped, no victim policy).
- Same-cycle lookup and update to the same index: lookup sees pre-update state; the new state is visible the next cycle. No bypass.
- Two updates to the same entry on consecutive cycles apply in order; each uses the state left by the previous edge.
- mispred_cnt_bp_o increments by 1 on each edge with upd_valid & mispred. It holds at 16'hFFFF, no wrap. mispred without upd_valid is ignored.
- Reset (rst_n=0 at an edge):
  - All valid bits = 0, all ctr = 01, all targets = 0, mispred_cnt = 0.
  - Any update presented in the same cycle is discarded.
  - Outputs during and after reset: brn_pred=0, brn_target=0.
  - Reset asserted mid-training erases all history in one edge.
- No stall input. While fetch is stalled the PC is held, so the outputs stay stable unless an update changes the indexed entry.
- Latency: prediction 0 cycles (combinational); update visible 1 cycle after the edge.

Test Plan:
- Post-reset lookup of any PC, e.g. 0x0040_0010 -> brn_pred=0, target=0, mispred_cnt=0.
- Update pc=0x0040_0010, taken, target=0x0040_0100. Next-cycle lookup of same PC -> brn_pred=1, target=0x0040_0100. Lookup of 0x0040_0014 -> brn_pred=0.
- Three taken updates, then three not-taken updates to 0x0040_0010; lookup after each:
  - Counter path 10 -> 11 -> 11 -> 10 -> 01 -> 00.
  - brn_pred: 1,1,1,1,0,0.
- Alias: train 0x0040_0010 taken, then update 0x0040_0050 (same index for IDX_W=4) not taken.
  - Lookup 0x0040_0010 -> brn_pred=0 (tag miss).
  - Lookup 0x0040_0050 -> brn_pred=0 (ctr 01).
- Same-cycle update (taken) and lookup of an untrained PC -> brn_pred=0 that cycle, brn_pred=1 the next.
- 70000 cycles with upd_valid=1 and mispred=1 -> count saturates at 0xFFFF.
  - Then assert rst_n=0 one cycle together with an update -> count 0, all lookups not taken, and the simultaneous update is not retained.
